bsg_encode_one_hot_serial: RTL
==============================

# bsg_encode_one_hot_serial

Sequential mask-to-index encoder: accepts a `width_p`-bit request mask, then emits the binary index of every set bit, one index per handshake, in priority order. It is the inverse of the binary-to-one-hot decode-with-valid path. It sits between a producer of multi-hot request vectors and a consumer that processes one binary address at a time.

## Interface
- `width_p`, default 16: mask width, ≥ 2.
- `lo_to_hi_p`, default 1: 1 = emit lowest set bit first; 0 = emit highest set bit first.
- `lg_width_lp`, derived: `$clog2(width_p)`, the index width.

Ports:
- `clk_i`, input, 1: clock.
- `reset_n_i`, input, 1: asynchronous, active-low reset.
- `i`, input, `width_p`: request mask.
- `v_i`, input, 1: mask valid.
- `ready_o`, output, 1: block can accept a mask.
- `addr_o`, output, `lg_width_lp`: encoded index of the current pending bit.
- `v_o`, output, 1: `addr_o` is valid.
- `last_o`, output, 1: `addr_o` is the final index of the current mask.
- `yumi_i`, input, 1: consumer takes `addr_o` this cycle. Legal only when `v_o` = 1.

## Operation
- State is a `width_p`-bit `pending_r` register plus a 2-state FSM, IDLE and BUSY.
- **IDLE**
  - `ready_o` = 1, `v_o` = 0.
  - On `v_i & ready_o` with `i` ≠ 0: `pending_r` ← `i`, go to BUSY.
  - On `v_i & ready_o` with `i` = 0: the mask is consumed and dropped. Stay in IDLE. No output.
- **BUSY**
  - `ready_o` = 0, `v_o` = 1. `v_i` is ignored and the mask is not captured.
  - `addr_o` = index of the priority set bit of `pending_r`: lowest when `lo_to_hi_p` = 1, highest otherwise.
  - `last_o` = 1 iff `pending_r` has exactly one bit set.
  - On `yumi_i`: clear that bit in `pending_r`. If `last_o` = 1, go to IDLE, leaving `pending_r` = 0.
  - With `yumi_i` low, `addr_o`, `v_o` and `last_o` hold stable.
- **Outputs:** `addr_o`, `v_o` and `last_o` are combinational functions of registered state only. They have no path from `i`, `v_i` or `yumi_i`.
- **Illegal input:** `yumi_i` while `v_o` = 0 is a protocol error. It has no effect on state; the bench flags it.
- **Invariant:** BUSY implies `pending_r` ≠ 0.
- **Width:** the encoder covers all `width_p` bits, including non-power-of-2 widths. `addr_o` is never ≥ `width_p` while `v_o` = 1.

## Timing
- **Reset values** while `reset_n_i` is low, taking effect immediately (async):
  - FSM = IDLE, `pending_r` = 0.
  - `v_o` = 0, `last_o` = 0, `addr_o` = 0.
  - `ready_o` = 0: it is gated low while reset is asserted.
- **After release:** `ready_o` = 1 in the first cycle with `reset_n_i` high.
- **Latency:** a mask accepted at edge N gives `v_o` = 1 in cycle N+1, with its first index.
- **Throughput:** with `yumi_i` held high, one index per cycle. A mask with k set bits occupies BUSY for exactly k cycles.
- **Inter-mask bubble:** the cycle after the last `yumi_i` is IDLE (`ready_o` = 1, `v_o` = 0). The next mask can be accepted that cycle, so there is one dead output cycle between masks.
- **Reset mid-operation:** all pending indices are discarded. No index from the aborted mask appears after release.

## Test plan
1. **Reset:** assert `reset_n_i` = 0 mid-cycle → `v_o`, `ready_o` and `last_o` drop to 0 without waiting for a clock edge. Release → `ready_o` = 1 next cycle, `v_o` = 0.
2. **Full throughput, `lo_to_hi_p` = 1:** `i` = 16'h8421 accepted, `yumi_i` held 1 → `addr_o` = 0, 5, 10, 15 on four consecutive cycles. `last_o` is 1 only with 15. `ready_o` = 1 the following cycle.
3. **Backpressure:** `i` = 16'h0006, `yumi_i` = 0 for 3 cycles → `addr_o` = 1 with `v_o` = 1 and `last_o` = 0, held stable for 3 cycles. Then `yumi_i` = 1 → next cycle `addr_o` = 2 with `last_o` = 1. Then `yumi_i` = 1 → IDLE.
4. **Descending order, `lo_to_hi_p` = 0:** `i` = 16'h8421 → `addr_o` = 15, 10, 5, 0.
5. **Zero mask and busy-ignore:**
   - `v_i` = 1 with `i` = 0 → `v_o` never asserts and `ready_o` stays 1.
   - During BUSY on 16'h0003, drive `v_i` = 1 with `i` = 16'hFFFF → the output sequence is exactly 0, 1.
6. **Reset mid-mask:** `i` = 16'hFFFF, pop 3 indices (0, 1, 2), then pulse reset → `v_o` = 0 immediately. After release, `ready_o` = 1 and no index 3..15 is ever emitted.

Source files
------------

// File: rtl/bsg_encode_one_hot_serial.sv
// -----------------------------------------------------------------------------
// bsg_encode_one_hot_serial
//
// Serial mask-to-index encoder. Accepts a width_p-bit multi-hot request mask
// and then hands out the binary index of every set bit, one per handshake, in
// priority order (lowest first when lo_to_hi_p = 1, highest first otherwise).
//
// Ports:
//   clk_i      - clock
//   reset_n_i  - asynchronous active-low reset
//   i          - request mask
//   v_i        - mask valid
//   ready_o    - block can accept a mask (held low while in reset)
//   addr_o     - index of the current pending bit
//   v_o        - addr_o is valid
//   last_o     - addr_o is the final index of the current mask
//   yumi_i     - consumer takes addr_o this cycle (only meaningful with v_o)
//
// State  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no pending bits; ready for a new mask, zero masks are dropped
// BUSY   | pending_r holds the not-yet-emitted bits, always non-zero here
// -----------------------------------------------------------------------------
module bsg_encode_one_hot_serial #(
    parameter  int width_p     = 16,
    parameter  bit lo_to_hi_p  = 1'b1,
    localparam int lg_width_lp = $clog2(width_p)
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic [width_p-1:0]     i,
    input  logic                   v_i,
    output logic                   ready_o,
    output logic [lg_width_lp-1:0] addr_o,
    output logic                   v_o,
    output logic                   last_o,
    input  logic                   yumi_i
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    localparam logic [width_p-1:0] one_lp = {{(width_p-1){1'b0}}, 1'b1};

    state_e                   state_r, state_n;
    logic [width_p-1:0]       pending_r, pending_n;
    logic [lg_width_lp-1:0]   pri_addr;
    logic [width_p-1:0]       pri_oh;
    logic                     single_bit;

    // Priority select over the registered mask only, so the outputs never
    // depend on i, v_i or yumi_i. The loop direction makes the winning bit
    // the last one assigned; every bit position is covered, so non-power-of-2
    // widths can never yield an index >= width_p.
    always_comb begin
        pri_addr = '0;
        pri_oh   = '0;
        if (lo_to_hi_p) begin
            for (int k = width_p - 1; k >= 0; k--) begin
                if (pending_r[k]) begin
                    pri_addr = k[lg_width_lp-1:0];
                    pri_oh   = one_lp << k;
                end
            end
        end else begin
            for (int k = 0; k < width_p; k++) begin
                if (pending_r[k]) begin
                    pri_addr = k[lg_width_lp-1:0];
                    pri_oh   = one_lp << k;
                end
            end
        end
    end

    // Exactly one bit set: clearing the lowest set bit leaves nothing.
    assign single_bit = (pending_r != '0) && ((pending_r & (pending_r - one_lp)) == '0);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r   <= IDLE;
            pending_r <= '0;
        end else begin
            state_r   <= state_n;
            pending_r <= pending_n;
        end
    end

    always_comb begin
        state_n   = state_r;
        pending_n = pending_r;
        case (state_r)
            IDLE: begin
                if (v_i && (i != '0)) begin
                    pending_n = i;
                    state_n   = BUSY;
                end
            end
            BUSY: begin
                if (yumi_i) begin
                    pending_n = pending_r & ~pri_oh;
                    if (single_bit) begin
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n   = IDLE;
                pending_n = '0;
            end
        endcase
    end

    // ready_o is gated by the reset pin so it drops the instant reset asserts.
    assign ready_o = (state_r == IDLE) && reset_n_i;
    assign v_o     = (state_r == BUSY);
    assign addr_o  = v_o ? pri_addr : '0;
    assign last_o  = v_o && single_bit;

endmodule
